bist_signature_analyzer: RTL and testbench

- Response side of the on-chip BIST loop. Sequences scan_en for the 8-bit scan chain (shift CHAIN_LEN cycles, then capture 1 cycle, repeated per pattern).
- Compacts the serial scan_out stream into a serial-input signature register (SISR).
- After the final flush, compares the signature against a golden value and reports pass/fail.
- Sits beside the pattern LFSR and scan chain at BIST top level; drives the chain's scan_en.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_sisr.sv | 29 ++
 rtl/bist_signature_analyzer.sv | 116 +++++++++++
 tb/tb_bist_signature_analyzer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: sequencer state encoding and default chain/signature constants.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int          BIST_CHAIN_LEN = 8;
    localparam logic [15:0] BIST_SIG_POLY  = 16'h1021;
    localparam logic [15:0] BIST_SIG_SEED  = 16'h0000;

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register: compacts one response bit per enabled edge.
module bist_sisr #(
    parameter int                   SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY  = 16'h1021
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [SIG_WIDTH-1:0] seed,
    input  logic                 en,
    input  logic                 din,
    output logic [SIG_WIDTH-1:0] sig
);

    logic [SIG_WIDTH-1:0] r_sig;
    logic                 w_fb;

    assign w_fb = r_sig[SIG_WIDTH-1] ^ din;
    assign sig  = r_sig;

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            r_sig <= seed;
        end else if (en) begin
            r_sig <= {r_sig[SIG_WIDTH-2:0], 1'b0} ^ (w_fb ? SIG_POLY : '0);
        end
    end

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response side: sequences scan_en over the chain, compacts scan_out into a SISR
// and compares the final signature against GOLDEN.
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int                   CHAIN_LEN    = BIST_CHAIN_LEN,
    parameter int                   NUM_PATTERNS = 16,
    parameter int                   SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY     = BIST_SIG_POLY,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED     = BIST_SIG_SEED,
    parameter logic [SIG_WIDTH-1:0] GOLDEN       = 16'h0000,
    localparam int                  PCW          = $clog2(NUM_PATTERNS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [PCW-1:0]       pattern_cnt
);

    localparam int             SCW       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [SCW-1:0] SHIFT_END = SCW'(CHAIN_LEN - 1);
    localparam logic [PCW-1:0] LAST_PAT  = PCW'(NUM_PATTERNS - 1);

    state_t               r_state;
    logic                 r_scan_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [PCW-1:0]       r_pcnt;
    logic [SCW-1:0]       r_scnt;
    logic                 w_load;
    logic                 w_compact;
    logic [SIG_WIDTH-1:0] w_sig;

    assign w_load = ((r_state == IDLE) || (r_state == DONE)) && start;
    // The first load only flushes pre-test chain contents, so it is not compacted.
    assign w_compact = ((r_state == SHIFT) && (r_pcnt != '0)) || (r_state == FLUSH);

    bist_sisr #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY)
    ) u_sisr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .seed  (SIG_SEED),
        .en    (w_compact),
        .din   (scan_out),
        .sig   (w_sig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_scan_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_pcnt    <= '0;
            r_scnt    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= SHIFT;
                        r_scan_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_pcnt    <= '0;
                        r_scnt    <= '0;
                    end
                end
                SHIFT, FLUSH: begin
                    if (r_scnt == SHIFT_END) begin
                        r_scnt    <= '0;
                        r_scan_en <= 1'b0;
                        r_state   <= (r_state == SHIFT) ? CAPTURE : COMPARE;
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_pcnt    <= r_pcnt + 1'b1;
                    r_scan_en <= 1'b1;
                    r_state   <= (r_pcnt == LAST_PAT) ? FLUSH : SHIFT;
                end
                COMPARE: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_sig == GOLDEN);
                end
                default: begin
                    r_state   <= IDLE;
                    r_scan_en <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign scan_en     = r_scan_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign signature   = w_sig;
    assign pattern_cnt = r_pcnt;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed and randomized bench for bist_signature_analyzer against a schedule-based reference model.
module tb_bist_signature_analyzer;

    localparam int TOTAL = 153;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        scan_out;
    logic        scan_en_a, busy_a, done_a, pass_a;
    logic        scan_en_b, busy_b, done_b, pass_b;
    logic [15:0] sig_a, sig_b;
    logic [4:0]  pcnt_a, pcnt_b;

    logic        stream [0:TOTAL];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bist_signature_analyzer #(.GOLDEN(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(scan_en_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .pattern_cnt(pcnt_a)
    );

    bist_signature_analyzer #(.GOLDEN(16'h1021)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(scan_en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .pattern_cnt(pcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle k (1-based after the start edge): 16 x (8 shift + 1 capture), 8 flush, 1 compare.
    function automatic logic exp_en(input int k);
        if (k <= 144) return ((k - 1) % 9) != 8;
        return k <= 152;
    endfunction

    // Reference: CRC-style polynomial division over every bit outside the discard window.
    function automatic logic [15:0] model_sig();
        logic [15:0] s;
        s = 16'h0000;
        for (int k = 1; k <= TOTAL; k++) begin
            if (exp_en(k) && k > 8)
                s = {s[14:0], 1'b0} ^ (((s[15] ^ stream[k]) == 1'b1) ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    task automatic clear_stream();
        for (int k = 0; k <= TOTAL; k++) stream[k] = 1'b0;
    endtask

    task automatic rand_stream();
        for (int k = 0; k <= TOTAL; k++) stream[k] = 1'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_scan_en"}, scan_en_a, 0);
        chk({tag, "_busy"},    busy_a,    0);
        chk({tag, "_done"},    done_a,    0);
        chk({tag, "_pass"},    pass_a,    0);
        chk({tag, "_sig"},     sig_a,     16'h0000);
        chk({tag, "_pcnt"},    pcnt_a,    0);
    endtask

    task automatic run(input string name, input int abort_at, input int repulse_at);
        logic [15:0] m;
        int pc;
        pc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, "_busy_start"}, busy_a, 1);
        chk({name, "_done_clr"},   done_a, 0);
        chk({name, "_sig_seed"},   sig_a,  16'h0000);
        for (int k = 1; k <= TOTAL; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1 check_reset_vals({name, "_abort"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk($sformatf("%s_scan_en_c%0d", name, k), scan_en_a, exp_en(k));
            chk($sformatf("%s_done_c%0d", name, k), done_a, 0);
            chk($sformatf("%s_pass_c%0d", name, k), pass_a, 0);
            chk($sformatf("%s_pcnt_c%0d", name, k), pcnt_a, pc);
            scan_out = stream[k];
            start    = (k == repulse_at);
            @(posedge clk);
            #1 start = 1'b0;
            if (k <= 144 && !exp_en(k)) pc++;
        end
        m = model_sig();
        chk({name, "_done"},    done_a,    1);
        chk({name, "_done_b"},  done_b,    1);
        chk({name, "_busy"},    busy_a,    0);
        chk({name, "_scan_en"}, scan_en_a, 0);
        chk({name, "_pcnt"},    pcnt_a,    16);
        chk({name, "_sig"},     sig_a,     m);
        chk({name, "_sig_b"},   sig_b,     m);
        chk({name, "_pass_g0"},    pass_a, m == 16'h0000);
        chk({name, "_pass_g1021"}, pass_b, m == 16'h1021);
        @(negedge clk);
        scan_out = 1'b0;
        chk({name, "_done_sticky"}, done_a, 1);
        chk({name, "_sig_hold"},    sig_a,  m);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        scan_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        clear_stream();
        run("zero", 0, 0);
        chk("zero_sig_const", sig_a, 16'h0000);
        chk("zero_pass", pass_a, 1);

        clear_stream();
        stream[152] = 1'b1;
        run("last_flush", 0, 0);
        chk("last_flush_const", sig_a, 16'h1021);
        chk("last_flush_pass_b", pass_b, 1);
        chk("last_flush_pass_a", pass_a, 0);

        clear_stream();
        stream[145] = 1'b1;
        run("first_flush", 0, 0);
        chk("first_flush_const", sig_a, 16'h9188);

        clear_stream();
        for (int k = 1; k <= 8; k++) stream[k] = 1'b1;
        run("discard", 0, 0);
        chk("discard_const", sig_a, 16'h0000);
        chk("discard_pass", pass_a, 1);

        for (int r = 0; r < 3; r++) begin
            rand_stream();
            run($sformatf("rand%0d", r), 0, 0);
        end

        rand_stream();
        run("repulse", 0, 50);

        rand_stream();
        run("abort", 80, 0);
        rand_stream();
        run("after_abort", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
